light_stretch_decoder: RTL

//  Parametrised successor to the per-track light decoding in the MusicView path.

---
 rtl/light_stretch_decoder_pkg.sv | 14 +
 rtl/light_stretch_decoder_code_onehot.sv | 26 ++
 rtl/light_stretch_decoder.sv | 109 ++++++++++
 3 files changed

// File: rtl/light_stretch_decoder_pkg.sv
// Shared definitions for the LED light decoder: display modes and the rest code.
package light_stretch_decoder_pkg;

   typedef enum logic [1:0] {
      LM_DIRECT = 2'd0,
      LM_HOLD   = 2'd1,
      LM_BLINK  = 2'd2,
      LM_OFF    = 2'd3
   } light_mode_e;

   // A note code of zero is a rest and never lights anything.
   localparam int REST_CODE = 0;

endpackage

// File: rtl/light_stretch_decoder_code_onehot.sv
// Combinational decode of one track's note code into a one-hot LED vector.
module light_code_onehot
   import light_stretch_decoder_pkg::*;
#(
   parameter int CODE_W   = 6,
   parameter int NUM_LEDS = 16
) (
   input  logic [CODE_W-1:0]   code,
   output logic [NUM_LEDS-1:0] onehot
);

   localparam int IDX_W = $clog2(NUM_LEDS);

   logic [IDX_W-1:0] idx;

   // Codes start at 1, so code-1 wraps onto the LED row by its low bits.
   assign idx = IDX_W'(code - CODE_W'(1));

   always_comb begin
      onehot = '0;
      if (code != CODE_W'(REST_CODE)) begin
         onehot[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/light_stretch_decoder.sv
// Multi-track note-to-LED decoder with per-LED hold/blink stretching on a slow tick.
module light_stretch_decoder
   import light_stretch_decoder_pkg::*;
#(
   parameter int NUM_TRACKS = 4,
   parameter int CODE_W     = 6,
   parameter int NUM_LEDS   = 16,
   parameter int HOLD_TICKS = 3,
   parameter int TICK_DIV   = 2500000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic [1:0]                   mode,
   input  logic [NUM_TRACKS-1:0]        track_mask,
   input  logic [NUM_TRACKS*CODE_W-1:0] tracks,
   output logic [NUM_LEDS-1:0]          light,
   output logic                         busy
);

   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CNT_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_TICKS);

   logic [NUM_LEDS-1:0] track_hot [NUM_TRACKS];
   logic [NUM_LEDS-1:0] raw;
   logic [NUM_LEDS-1:0] hit;
   logic [NUM_LEDS-1:0] cnt_live;
   logic [PRE_W-1:0]    pre_cnt;
   logic                tick;
   logic                blink_phase;

   for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_track
      light_code_onehot #(
         .CODE_W   (CODE_W),
         .NUM_LEDS (NUM_LEDS)
      ) u_dec (
         .code   (tracks[t*CODE_W +: CODE_W]),
         .onehot (track_hot[t])
      );
   end

   always_comb begin
      raw = '0;
      for (int t = 0; t < NUM_TRACKS; t++) begin
         if (track_mask[t]) begin
            raw = raw | track_hot[t];
         end
      end
   end

   assign hit  = raw & {NUM_LEDS{in_valid}};
   assign tick = (pre_cnt == PRE_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_cnt     <= '0;
         blink_phase <= 1'b0;
      end else begin
         pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
         if (tick) begin
            blink_phase <= ~blink_phase;
         end
      end
   end

   // A fresh hit reloads the counter even on a tick cycle, so retriggers extend the stretch.
   for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      always_comb begin
         cnt_d = cnt_q;
         if (hit[i]) begin
            cnt_d = CNT_LOAD;
         end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign cnt_live[i] = (cnt_d != '0);
   end

   // Next-state counters drive the outputs so an LED goes dark right after its final tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         light <= '0;
         busy  <= 1'b0;
      end else begin
         busy <= |cnt_live;
         case (light_mode_e'(mode))
            LM_DIRECT: light <= raw;
            LM_HOLD:   light <= hit | cnt_live;
            LM_BLINK:  light <= hit | (cnt_live & {NUM_LEDS{blink_phase}});
            default:   light <= '0;
         endcase
      end
   end

endmodule
